// File: rtl/s2mm_stream_feeder.sv
// s2mm_stream_feeder: buffers a 64-bit stream and issues datamover write commands into a ring buffer.
// Define FEEDER_PKT_CNT_EN to add the o_pkt_cnt packet counter output.
module s2mm_stream_feeder #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int unsigned REGION_BYTES = 65536,
    parameter int unsigned BURST_WORDS  = 16,
    parameter int unsigned FIFO_DEPTH   = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_tvalid,
    output logic        s_tready,
    input  logic        s_tlast,
    input  logic [63:0] s_tdata,
    output logic [31:0] o_wr_cmd_addr,
    output logic [22:0] o_wr_cmd_length,
    output logic        o_wr_cmd_req,
    input  logic        i_wr_cmd_ack,
    output logic        o_wr_valid,
    output logic [63:0] o_wr_data,
    input  logic        i_wr_ready,
    input  logic        i_write_finish,
`ifdef FEEDER_PKT_CNT_EN
    output logic [15:0] o_pkt_cnt,
`endif
    output logic        o_busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int LW = $clog2(BURST_WORDS + 1);
    localparam logic [CW-1:0] BURST_C = CW'(BURST_WORDS);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [32:0] LIMIT = 33'(BASE_ADDR) + 33'(REGION_BYTES);
    localparam logic [32:0] BURST_BYTES = 33'(BURST_WORDS * 8);

    typedef enum logic [1:0] {IDLE, CMD, DATA, WAIT_FIN} state_t;

    state_t        state_q, state_d;
    logic [63:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] count_q;
    logic          tail_q, tail_d;
    logic          cmd_tail_q, cmd_tail_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] left_q, left_d;
    logic [31:0]   cur_q, cur_d;
    logic [31:0]   addr_q, addr_d;
    logic [22:0]   length_q, length_d;
    logic          push, pop, full;
    logic [32:0]   next_addr;

    assign full       = (count_q == DEPTH_C);
    assign s_tready   = !rst && !full && !tail_q;
    assign push       = s_tvalid && s_tready;
    assign o_wr_valid = (state_q == DATA) && (left_q != '0);
    assign pop        = o_wr_valid && i_wr_ready;
    assign o_wr_data  = rst ? '0 : mem_q[rptr_q];
    assign o_wr_cmd_req    = (state_q == CMD);
    assign o_wr_cmd_addr   = addr_q;
    assign o_wr_cmd_length = length_q;
    assign o_busy          = (state_q != IDLE);
    assign next_addr = 33'(cur_q) + 33'({len_q, 3'b000});

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= s_tdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop) rptr_q <= rptr_q + 1'b1;
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            tail_q     <= 1'b0;
            cmd_tail_q <= 1'b0;
            len_q      <= '0;
            left_q     <= '0;
            cur_q      <= BASE_ADDR;
            addr_q     <= '0;
            length_q   <= '0;
        end else begin
            state_q    <= state_d;
            tail_q     <= tail_d;
            cmd_tail_q <= cmd_tail_d;
            len_q      <= len_d;
            left_q     <= left_d;
            cur_q      <= cur_d;
            addr_q     <= addr_d;
            length_q   <= length_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tail_d     = tail_q;
        cmd_tail_d = cmd_tail_q;
        len_d      = len_q;
        left_d     = left_q;
        cur_d      = cur_q;
        addr_d     = addr_q;
        length_d   = length_q;
        if (push && s_tlast) tail_d = 1'b1;
        unique case (state_q)
            IDLE: begin
                if (count_q >= BURST_C || (tail_q && count_q != '0)) begin
                    len_d    = (count_q >= BURST_C) ? LW'(BURST_WORDS) : LW'(count_q);
                    left_d   = len_d;
                    addr_d   = cur_q;
                    length_d = 23'({len_d, 3'b000});
                    // No pushes while tail is held, so the tlast word is the FIFO's last
                    cmd_tail_d = tail_q && (count_q <= BURST_C);
                    state_d  = CMD;
                end
            end
            CMD: begin
                if (i_wr_cmd_ack) state_d = DATA;
            end
            DATA: begin
                if (pop) begin
                    left_d = left_q - 1'b1;
                    if (left_q == LW'(1)) state_d = WAIT_FIN;
                end
            end
            WAIT_FIN: begin
                if (i_write_finish) begin
                    cur_d = (next_addr + BURST_BYTES > LIMIT) ? BASE_ADDR : next_addr[31:0];
                    if (cmd_tail_q) tail_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef FEEDER_PKT_CNT_EN
    logic [15:0] pkt_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pkt_cnt_q <= '0;
        else if (push && s_tlast) pkt_cnt_q <= pkt_cnt_q + 16'd1;
    end

    assign o_pkt_cnt = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_s2mm_stream_feeder.sv
// tb_s2mm_stream_feeder: directed bench for s2mm_stream_feeder with a 256-byte ring.
// Inputs are driven and handshakes observed on the falling clock edge.
module tb_s2mm_stream_feeder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic        s_tlast = 1'b0;
    logic [63:0] s_tdata = '0;
    logic [31:0] o_wr_cmd_addr;
    logic [22:0] o_wr_cmd_length;
    logic        o_wr_cmd_req;
    logic        i_wr_cmd_ack;
    logic        o_wr_valid;
    logic [63:0] o_wr_data;
    logic        i_wr_ready;
    logic        i_write_finish;
    logic        o_busy;
`ifdef FEEDER_PKT_CNT_EN
    logic [15:0] o_pkt_cnt;
`endif

    s2mm_stream_feeder #(
        .BASE_ADDR   (32'h0000_0000),
        .REGION_BYTES(256),
        .BURST_WORDS (16),
        .FIFO_DEPTH  (32)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .s_tvalid       (s_tvalid),
        .s_tready       (s_tready),
        .s_tlast        (s_tlast),
        .s_tdata        (s_tdata),
        .o_wr_cmd_addr  (o_wr_cmd_addr),
        .o_wr_cmd_length(o_wr_cmd_length),
        .o_wr_cmd_req   (o_wr_cmd_req),
        .i_wr_cmd_ack   (i_wr_cmd_ack),
        .o_wr_valid     (o_wr_valid),
        .o_wr_data      (o_wr_data),
        .i_wr_ready     (i_wr_ready),
        .i_write_finish (i_write_finish),
`ifdef FEEDER_PKT_CNT_EN
        .o_pkt_cnt      (o_pkt_cnt),
`endif
        .o_busy         (o_busy)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;
    logic [63:0] exp_q[$];
    logic [31:0] cmd_addr[$];
    logic [22:0] cmd_len[$];
    int xfers = 0;
    int req_hold = 0;
    int req_cycles = 0;
    int words_left = 0;
    int fin_delay = 0;
    int ack_delay = 1;
    int ready_mode = 0;
    int pkts = 0;
    int stalls = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ca(input int i);
        return (i < cmd_addr.size()) ? 64'(cmd_addr[i]) : '1;
    endfunction

    function automatic logic [63:0] cl(input int i);
        return (i < cmd_len.size()) ? 64'(cmd_len[i]) : '1;
    endfunction

    // Datamover model: ack after ack_delay request cycles, finish two cycles after the last beat
    initial begin
        logic [63:0] ew;
        i_wr_cmd_ack = 1'b0;
        i_wr_ready = 1'b0;
        i_write_finish = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                i_wr_cmd_ack = 1'b0;
                i_wr_ready = 1'b0;
                i_write_finish = 1'b0;
                fin_delay = 0;
                req_cycles = 0;
                words_left = 0;
            end else begin
                i_write_finish = 1'b0;
                if (fin_delay > 0) begin
                    fin_delay--;
                    i_write_finish = (fin_delay == 0);
                end
                if (o_wr_cmd_req) begin
                    req_cycles++;
                    i_wr_cmd_ack = (req_cycles >= ack_delay);
                end else begin
                    i_wr_cmd_ack = 1'b0;
                end
                i_wr_ready = (ready_mode == 0) ? 1'b1 : !i_wr_ready;
                if (o_wr_cmd_req && i_wr_cmd_ack) begin
                    cmd_addr.push_back(o_wr_cmd_addr);
                    cmd_len.push_back(o_wr_cmd_length);
                    req_hold = req_cycles;
                    req_cycles = 0;
                    words_left = int'(o_wr_cmd_length) / 8;
                end
                if (o_wr_valid && i_wr_ready) begin
                    ew = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                    chk("wr_data", o_wr_data, ew);
                    xfers++;
                    words_left--;
                    if (words_left == 0) fin_delay = 2;
                end
            end
        end
    end

    task automatic send(input int n, input bit last, input logic [63:0] seed);
        int guard;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            s_tvalid = 1'b1;
            s_tdata = seed + 64'(i);
            s_tlast = last && (i == n - 1);
            guard = 0;
            while (!s_tready && guard < 3000) begin
                stalls++;
                @(negedge clk);
                guard++;
            end
            if (!s_tready) begin
                chk("send_timeout", 64'(s_tready), 64'd1);
                break;
            end
            exp_q.push_back(s_tdata);
            if (s_tlast) pkts++;
        end
        @(negedge clk);
        s_tvalid = 1'b0;
        s_tlast = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || o_busy || fin_delay != 0) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_idle"}, 64'(o_busy), 64'd0);
        chk({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic new_test();
        cmd_addr.delete();
        cmd_len.delete();
        xfers = 0;
        stalls = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req"}, 64'(o_wr_cmd_req), 64'd0);
        chk({tag, "_valid"}, 64'(o_wr_valid), 64'd0);
        chk({tag, "_busy"}, 64'(o_busy), 64'd0);
        chk({tag, "_addr"}, 64'(o_wr_cmd_addr), 64'd0);
        chk({tag, "_len"}, 64'(o_wr_cmd_length), 64'd0);
        chk({tag, "_data"}, o_wr_data, 64'd0);
        chk({tag, "_tready"}, 64'(s_tready), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit seen;
        int viol;

        #1;
        check_reset_outputs("rst0");
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        #1 chk("rst0_tready_after", 64'(s_tready), 64'd1);

        // 16 words, no tlast: one full burst at the ring base
        new_test();
        send(16, 1'b0, 64'h1000);
        wait_idle("t31");
        chk("t31_ncmd", 64'(cmd_addr.size()), 64'd1);
        chk("t31_addr", ca(0), 64'h0);
        chk("t31_len", cl(0), 64'd128);
        chk("t31_xfers", 64'(xfers), 64'd16);

        // Reset while 8 words remain in DATA
        new_test();
        send(16, 1'b0, 64'h2000);
        n = 0;
        while (words_left != 8 && n < 500) begin
            @(posedge clk);
            n++;
        end
        chk("t35_pre_addr", ca(0), 64'h80);
        #2 rst = 1'b1;
        #1 check_reset_outputs("t35");
        exp_q.delete();
        pkts = 0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        #1 chk("t35_tready_after", 64'(s_tready), 64'd1);
        chk("t35_busy_after", 64'(o_busy), 64'd0);
        new_test();
        send(16, 1'b0, 64'h3000);
        wait_idle("t35b");
        chk("t35_addr", ca(0), 64'h0);
        chk("t35_len", cl(0), 64'd128);
        chk("t35_xfers", 64'(xfers), 64'd16);

        // Short packet: 5 words with tlast, input blocked until finish
        new_test();
        send(5, 1'b1, 64'h4000);
        seen = 1'b0;
        viol = 0;
        n = 0;
        while (n < 500) begin
            if (o_busy) seen = 1'b1;
            if (seen && !o_busy) break;
            if (s_tready) viol++;
            @(negedge clk);
            n++;
        end
        chk("t32_tready_held", 64'(viol), 64'd0);
        chk("t32_tready_release", 64'(s_tready), 64'd1);
        wait_idle("t32");
        chk("t32_addr", ca(0), 64'h80);
        chk("t32_len", cl(0), 64'd40);

        // 40 words with tlast on the last: ring wraps to base for the third command
        new_test();
        send(40, 1'b1, 64'h5000);
        wait_idle("t33");
        chk("t33_ncmd", 64'(cmd_addr.size()), 64'd3);
        chk("t33_addr0", ca(0), 64'h00);
        chk("t33_addr1", ca(1), 64'h80);
        chk("t33_addr2", ca(2), 64'h00);
        chk("t33_len0", cl(0), 64'd128);
        chk("t33_len1", cl(1), 64'd128);
        chk("t33_len2", cl(2), 64'd64);
        chk("t33_xfers", 64'(xfers), 64'd40);

        // Slow ack and toggling ready
        new_test();
        ack_delay = 10;
        ready_mode = 1;
        send(16, 1'b0, 64'h6000);
        wait_idle("t34");
        chk("t34_addr", ca(0), 64'h40);
        chk("t34_len", cl(0), 64'd128);
        chk("t34_req_hold", 64'(req_hold), 64'd10);
        chk("t34_xfers", 64'(xfers), 64'd16);
        ready_mode = 0;

        // Very slow ack fills the FIFO and stalls the stream
        new_test();
        ack_delay = 30;
        send(36, 1'b1, 64'h7000);
        chk("t36_stalled", 64'(stalls > 0), 64'd1);
        wait_idle("t36");
        chk("t36_addr2", ca(2), 64'h00);
        chk("t36_len2", cl(2), 64'd32);
        chk("t36_xfers", 64'(xfers), 64'd36);
        ack_delay = 1;

        // Three 4-word packets
        new_test();
        send(4, 1'b1, 64'h8000);
        send(4, 1'b1, 64'h8100);
        send(4, 1'b1, 64'h8200);
        wait_idle("tpk");
        chk("tpk_ncmd", 64'(cmd_addr.size()), 64'd3);
        chk("tpk_addr0", ca(0), 64'h20);
        chk("tpk_addr2", ca(2), 64'h60);
        chk("tpk_len1", cl(1), 64'd32);
        chk("tpk_xfers", 64'(xfers), 64'd12);
`ifdef FEEDER_PKT_CNT_EN
        chk("tpk_pkt_cnt", 64'(o_pkt_cnt), 64'(pkts));
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
